hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Produces stall, flush and forwarding controls for the IF/ID, ID/EX and EX/MEM path; drives flushE into the ID/EX register and the new stallE hold enable.
- Sequences multi-cycle divide stalls with an internal FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
DIV_CYCLES, 8, divider latency in cycles; legal range 2..255
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rsD  in  5  rs field of instruction in D
rtD  in  5  rt field of instruction in D
rsE  in  5  rs field in E
rtE  in  5  rt field in E
writeRegE  in  5  destination register in E
writeRegM  in  5  destination register in M
writeRegW  in  5  destination register in W
regWriteE  in  1  E writes regfile
regWriteM  in  1  M writes regfile
regWriteW  in  1  W writes regfile
memToRegE  in  1  E is a load
memToRegM  in  1  M is a load
branchD  in  1  D is a branch
pcSrcD  in  1  D branch resolved taken
jumpD  in  1  D is a jump
divStartE  in  1  E holds a divide
stallF  out  1  hold PC
stallD  out  1  hold IF/ID
stallE  out  1  hold ID/EX
flushD  out  1  clear IF/ID
flushE  out  1  clear ID/EX (bubble)
forwardAE  out  2  ALU src A select: 00 regfile, 01 W result, 10 M ALU result
forwardBE  out  2  ALU src B select, same encoding as forwardAE
forwardAD  out  1  branch comparator A takes M ALU result
forwardBD  out  1  branch comparator B takes M ALU result
divBusy  out  1  divide stall active
divDone  out  1  one-cycle pulse in divide completion cycle
stallCount  out  CNT_W  cycles with stallF=1
flushCount  out  CNT_W  cycles with flushE=1

Behaviour:
- Register $0 never matches: every compare requires its source field != 0.
- Forwarding:
  - forwardAE = 10 if regWriteM & writeRegM==rsE.
  - Otherwise forwardAE = 01 if regWriteW & writeRegW==rsE.
  - Otherwise 00. M has priority over W. forwardBE uses rtE identically.
  - forwardAD = regWriteM & writeRegM==rsD. forwardBD uses rtD.
- lwstall = memToRegE & (rtE==rsD | rtE==rtD).
- branchstall = branchD & ((regWriteE & writeRegE∈{rsD,rtD}) | (memToRegM & writeRegM∈{rsD,rtD})).
- divStall = (IDLE & divStartE) | (BUSY & cnt!=0).
- Output equations:
  - stallF = stallD = lwstall | branchstall | divStall.
  - stallE = divStall.
  - flushE = (lwstall | branchstall) & ~divStall.
  - flushD = (pcSrcD | jumpD) & ~stallD.
- FSM states:
  - IDLE: divStartE loads cnt = DIV_CYCLES-1, next state BUSY.
  - BUSY with cnt>0: cnt decrements.
  - BUSY with cnt==0: divDone=1, divStall=0, next state IDLE.
  - divStartE is ignored outside IDLE.
  - Net effect: stall lasts exactly DIV_CYCLES cycles (start cycle included), then one done cycle in which the divide advances.
- divBusy = divStall.
- Counters:
  - stallCount increments in each cycle with stallF=1.
  - flushCount increments in each cycle with flushE=1.
  - Both saturate at all-ones and never wrap.
- Reset (cycle rst=1):
  - stallF/D/E, flushD, divBusy, divDone and forwards are forced 0; flushE is forced 1.
  - State returns to IDLE, cnt=0, both counters=0.
  - Reset mid-BUSY aborts with no divDone. divStartE in the reset cycle is ignored.
  - Counters do not count during reset.

Decomposition:
- Shared package (defines.vh): FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; HZ_IDLE/HZ_BUSY state encodings; REG_SIZE width reused.
- One sub-module: sat_counter (CNT_W, inc, rst), instantiated twice for the performance counters.
- Forwarding and stall equations stay inline.

Test Plan:
- Forwarding: regWriteM=1, writeRegM=5, regWriteW=1, writeRegW=5, rsE=5, rtE=0 -> forwardAE=10, forwardBE=00. Drop regWriteM -> forwardAE=01. writeRegM=0, rsE=0 -> 00.
- Load-use: memToRegE=1, rtE=8, rsD=8 -> stallF=stallD=1, flushE=1, flushD=0 for one cycle. flushCount increments by 1. With rtE=0 -> no stall.
- Branch: branchD=1, regWriteE=1, writeRegE=3, rtD=3 -> stall+flushE. Next cycle, with E holding the M-stage writer, forwardBD=1, pcSrcD=1 -> flushD=1, no stall.
- Divide: DIV_CYCLES=4, divStartE high at cycle t and held -> stallE/stallF=1 at t..t+3, divDone=1 at t+4 with no stall, IDLE at t+5. stallCount=4. lwstall coincident during t..t+3 -> flushE=0.
- Reset mid-divide: rst at t+2 -> all stalls 0, flushE=1 that cycle, no divDone, counters 0, next divStartE restarts a full 4-cycle stall.
- Saturation: CNT_W=3, hold lwstall for 10 cycles -> stallCount climbs to 7 and stays 7.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int REG_SIZE = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

  // Register $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(logic [REG_SIZE-1:0] src, logic [REG_SIZE-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_ctrl_pkg::*;

  logic [REG_SIZE-1:0] rsD, rtD, rsE, rtE;
  logic [REG_SIZE-1:0] writeRegE, writeRegM, writeRegW;
  logic regWriteE, regWriteM, regWriteW;
  logic memToRegE, memToRegM;
  logic branchD, pcSrcD, jumpD, divStartE;

  logic stallF, stallD, stallE, flushD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD;
  logic divBusy, divDone;
  logic [CNT_W-1:0] stallCount, flushCount;

  modport master (
    output rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
           branchD, pcSrcD, jumpD, divStartE,
    input  stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, divBusy, divDone, stallCount, flushCount
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, memToRegM,
           branchD, pcSrcD, jumpD, divStartE,
    output stallF, stallD, stallE, flushD, flushE, forwardAE, forwardBE,
           forwardAD, forwardBD, divBusy, divDone, stallCount, flushCount
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage pipeline, with a
// multi-cycle divide stall sequencer and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       div_stall, div_done;
  logic       lwstall, branchstall, stall_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall covers the start cycle plus DIV_CYCLES-1 BUSY cycles; cnt==0 is the done cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_stall = 1'b0;
    div_done  = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (hz.divStartE) begin
          div_stall = 1'b1;
          cnt_d     = DIV_LOAD;
          state_d   = HZ_BUSY;
        end
      end
      HZ_BUSY: begin
        if (cnt_q != '0) begin
          div_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          div_done = 1'b1;
          state_d  = HZ_IDLE;
        end
      end
      default: state_d = HZ_IDLE;
    endcase
    if (rst) begin
      div_stall = 1'b0;
      div_done  = 1'b0;
    end
  end

  always_comb begin
    lwstall     = hz.memToRegE &
                  (reg_match(hz.rsD, hz.rtE) | reg_match(hz.rtD, hz.rtE));
    branchstall = hz.branchD &
                  ((hz.regWriteE & (reg_match(hz.rsD, hz.writeRegE) | reg_match(hz.rtD, hz.writeRegE))) |
                   (hz.memToRegM & (reg_match(hz.rsD, hz.writeRegM) | reg_match(hz.rtD, hz.writeRegM))));
    stall_any   = lwstall | branchstall | div_stall;

    hz.forwardAE = FWD_REG;
    hz.forwardBE = FWD_REG;
    if (hz.regWriteM && reg_match(hz.rsE, hz.writeRegM))      hz.forwardAE = FWD_MEM;
    else if (hz.regWriteW && reg_match(hz.rsE, hz.writeRegW)) hz.forwardAE = FWD_WB;
    if (hz.regWriteM && reg_match(hz.rtE, hz.writeRegM))      hz.forwardBE = FWD_MEM;
    else if (hz.regWriteW && reg_match(hz.rtE, hz.writeRegW)) hz.forwardBE = FWD_WB;
    hz.forwardAD = hz.regWriteM & reg_match(hz.rsD, hz.writeRegM);
    hz.forwardBD = hz.regWriteM & reg_match(hz.rtD, hz.writeRegM);

    hz.stallF  = stall_any;
    hz.stallD  = stall_any;
    hz.stallE  = div_stall;
    hz.flushE  = (lwstall | branchstall) & ~div_stall;
    hz.flushD  = (hz.pcSrcD | hz.jumpD) & ~stall_any;
    hz.divBusy = div_stall;
    hz.divDone = div_done;

    // Reset holds a bubble in ID/EX and suppresses every other control.
    if (rst) begin
      hz.forwardAE = FWD_REG;
      hz.forwardBE = FWD_REG;
      hz.forwardAD = 1'b0;
      hz.forwardBD = 1'b0;
      hz.stallF    = 1'b0;
      hz.stallD    = 1'b0;
      hz.stallE    = 1'b0;
      hz.flushD    = 1'b0;
      hz.flushE    = 1'b1;
      hz.divBusy   = 1'b0;
      hz.divDone   = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hz.stallF),
    .count_o (hz.stallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (hz.flushE),
    .count_o (hz.flushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic.
module tb_hazard_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 3;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    int stallF, stallD, stallE, flushD, flushE;
    int fAE, fBE, fAD, fBD, divBusy, divDone;
    int sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int div_left  = 0;
  int in_div    = 0;
  int done_next = 0;
  int sc_m      = 0;
  int fc_m      = 0;

  function automatic int m(int src, int dst);
    return (src != 0 && src == dst) ? 1 : 0;
  endfunction

  function automatic int fwd_e(int src);
    if (hz.regWriteM && m(src, hz.writeRegM)) return 2;
    if (hz.regWriteW && m(src, hz.writeRegW)) return 1;
    return 0;
  endfunction

  task automatic model_step();
    exp_t e;
    int lw, br, dv, dn, hz_stall;
    e.sc = sc_m;
    e.fc = fc_m;
    if (rst) begin
      e.stallF = 0; e.stallD = 0; e.stallE = 0; e.flushD = 0; e.flushE = 1;
      e.fAE = 0; e.fBE = 0; e.fAD = 0; e.fBD = 0; e.divBusy = 0; e.divDone = 0;
      in_div = 0; div_left = 0; done_next = 0; sc_m = 0; fc_m = 0;
    end else begin
      dv = 0; dn = 0;
      if (in_div && div_left > 0) begin
        dv = 1;
        div_left--;
        if (div_left == 0) done_next = 1;
      end else if (done_next) begin
        dn = 1; done_next = 0; in_div = 0;
      end else if (hz.divStartE) begin
        dv = 1; in_div = 1; div_left = DIV_CYCLES - 1;
      end
      lw = hz.memToRegE && (m(hz.rsD, hz.rtE) || m(hz.rtD, hz.rtE));
      br = hz.branchD && ((hz.regWriteE && (m(hz.rsD, hz.writeRegE) || m(hz.rtD, hz.writeRegE))) ||
                          (hz.memToRegM && (m(hz.rsD, hz.writeRegM) || m(hz.rtD, hz.writeRegM))));
      hz_stall = (lw || br || dv) ? 1 : 0;
      e.stallF = hz_stall; e.stallD = hz_stall; e.stallE = dv;
      e.flushE = ((lw || br) && !dv) ? 1 : 0;
      e.flushD = ((hz.pcSrcD || hz.jumpD) && !hz_stall) ? 1 : 0;
      e.fAE = fwd_e(hz.rsE);
      e.fBE = fwd_e(hz.rtE);
      e.fAD = (hz.regWriteM && m(hz.rsD, hz.writeRegM)) ? 1 : 0;
      e.fBD = (hz.regWriteM && m(hz.rtD, hz.writeRegM)) ? 1 : 0;
      e.divBusy = dv; e.divDone = dn;
      if (e.stallF) sc_m = (sc_m < MAXC) ? sc_m + 1 : MAXC;
      if (e.flushE) fc_m = (fc_m < MAXC) ? fc_m + 1 : MAXC;
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.writeRegE = 0; hz.writeRegM = 0; hz.writeRegW = 0;
    hz.regWriteE = 0; hz.regWriteM = 0; hz.regWriteW = 0;
    hz.memToRegE = 0; hz.memToRegM = 0;
    hz.branchD = 0; hz.pcSrcD = 0; hz.jumpD = 0; hz.divStartE = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stallF",     int'(hz.stallF),     e.stallF);
      chk("stallD",     int'(hz.stallD),     e.stallD);
      chk("stallE",     int'(hz.stallE),     e.stallE);
      chk("flushD",     int'(hz.flushD),     e.flushD);
      chk("flushE",     int'(hz.flushE),     e.flushE);
      chk("forwardAE",  int'(hz.forwardAE),  e.fAE);
      chk("forwardBE",  int'(hz.forwardBE),  e.fBE);
      chk("forwardAD",  int'(hz.forwardAD),  e.fAD);
      chk("forwardBD",  int'(hz.forwardBD),  e.fBD);
      chk("divBusy",    int'(hz.divBusy),    e.divBusy);
      chk("divDone",    int'(hz.divDone),    e.divDone);
      chk("stallCount", int'(hz.stallCount), e.sc);
      chk("flushCount", int'(hz.flushCount), e.fc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Forwarding priority and $0 exclusion
    hz.regWriteM = 1; hz.writeRegM = 5; hz.regWriteW = 1; hz.writeRegW = 5; hz.rsE = 5; hz.rtE = 0;
    cycle();
    hz.regWriteM = 0;
    cycle();
    hz.writeRegM = 0; hz.rsE = 0;
    cycle();
    clear_inputs();

    // Load-use
    hz.memToRegE = 1; hz.rtE = 8; hz.rsD = 8;
    cycle();
    hz.rtE = 0;
    cycle();
    clear_inputs();

    // Branch dependent on E, then resolved with M forwarding
    hz.branchD = 1; hz.regWriteE = 1; hz.writeRegE = 3; hz.rtD = 3;
    cycle();
    hz.regWriteE = 0; hz.writeRegE = 0; hz.regWriteM = 1; hz.writeRegM = 3; hz.pcSrcD = 1;
    cycle();
    clear_inputs();
    cycle();

    // Divide held high with a coincident load-use
    hz.divStartE = 1; hz.memToRegE = 1; hz.rtE = 8; hz.rsD = 8;
    repeat (4) cycle();
    hz.memToRegE = 0;
    repeat (2) cycle();
    clear_inputs();
    repeat (6) cycle();

    // Reset in the middle of a divide, then a full restart
    hz.divStartE = 1;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (6) cycle();
    clear_inputs();
    repeat (2) cycle();

    // Counter saturation
    rst = 1'b1; cycle(); rst = 1'b0;
    hz.memToRegE = 1; hz.rtE = 8; hz.rsD = 8;
    repeat (10) cycle();
    clear_inputs();
    cycle();

    // Randomized traffic on a small register window to provoke matches
    for (int i = 0; i < 800; i++) begin
      rst          = ($urandom_range(0, 99) < 3);
      hz.rsD       = 5'($urandom_range(0, 3));
      hz.rtD       = 5'($urandom_range(0, 3));
      hz.rsE       = 5'($urandom_range(0, 3));
      hz.rtE       = 5'($urandom_range(0, 3));
      hz.writeRegE = 5'($urandom_range(0, 3));
      hz.writeRegM = 5'($urandom_range(0, 3));
      hz.writeRegW = 5'($urandom_range(0, 3));
      hz.regWriteE = 1'($urandom_range(0, 1));
      hz.regWriteM = 1'($urandom_range(0, 1));
      hz.regWriteW = 1'($urandom_range(0, 1));
      hz.memToRegE = ($urandom_range(0, 3) == 0);
      hz.memToRegM = ($urandom_range(0, 3) == 0);
      hz.branchD   = ($urandom_range(0, 2) == 0);
      hz.pcSrcD    = 1'($urandom_range(0, 1));
      hz.jumpD     = ($urandom_range(0, 5) == 0);
      hz.divStartE = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rst = 1'b0;
    clear_inputs();
    cycle();
    @(negedge clk);
    #1;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
